// File: rtl/light_controller_if.sv
// light_controller_if: control inputs and light status between mode logic, light controller and driver
interface light_controller_if #(
  parameter int CW = 9
);
  logic          power_on;
  logic          btn_toggle;
  logic          clean_req;
  logic          sec_tick;
  logic          light;
  logic [1:0]    light_state;
  logic [CW-1:0] remain_s;
  modport master (
    output power_on, btn_toggle, clean_req, sec_tick,
    input  light, light_state, remain_s
  );
  modport slave (
    input  power_on, btn_toggle, clean_req, sec_tick,
    output light, light_state, remain_s
  );
endinterface

// File: rtl/light_controller.sv
// light_controller: hood light sequencer with manual toggle, forced-on cleaning and blinking auto-off
module light_controller #(
  parameter int AUTO_OFF_S = 300,
  parameter int WARN_S     = 10,
  parameter int CW         = 9
) (
  input  logic               clk,
  input  logic               reset,
  light_controller_if.slave  bus
);
  typedef enum logic [1:0] {
    S_OFF    = 2'b00,
    S_ON     = 2'b01,
    S_WARN   = 2'b10,
    S_FORCED = 2'b11
  } state_t;
  localparam logic [CW-1:0] AUTO_V = CW'(AUTO_OFF_S);
  localparam logic [CW-1:0] WARN_V = CW'(WARN_S);
  if (AUTO_OFF_S < 1 || WARN_S < 0 || WARN_S >= AUTO_OFF_S || AUTO_OFF_S >= 2**CW) begin : g_bad_params
    $fatal(1, "light_controller: illegal AUTO_OFF_S/WARN_S/CW combination");
  end
  state_t        state_q, state_d;
  logic          light_q, light_d;
  logic [CW-1:0] remain_q, remain_d;
  logic [CW-1:0] dec;
  // state, light and countdown registers; reset forces the light off immediately
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_OFF;
      light_q  <= 1'b0;
      remain_q <= '0;
    end else begin
      state_q  <= state_d;
      light_q  <= light_d;
      remain_q <= remain_d;
    end
  end
  // next state in priority order: power loss, cleaning, button, second tick
  always_comb begin
    dec      = (remain_q == '0) ? '0 : remain_q - CW'(1);
    state_d  = state_q;
    light_d  = light_q;
    remain_d = remain_q;
    if (!bus.power_on) begin
      state_d  = S_OFF;
      light_d  = 1'b0;
      remain_d = '0;
    end else if (bus.clean_req) begin
      state_d  = S_FORCED;
      light_d  = 1'b1;
      remain_d = AUTO_V;
    end else begin
      case (state_q)
        S_OFF: begin
          if (bus.btn_toggle) begin
            state_d  = S_ON;
            light_d  = 1'b1;
            remain_d = AUTO_V;
          end
        end
        S_ON: begin
          if (bus.btn_toggle) begin
            state_d  = S_OFF;
            light_d  = 1'b0;
            remain_d = '0;
          end else if (bus.sec_tick) begin
            remain_d = dec;
            if (dec == '0) begin
              state_d = S_OFF;
              light_d = 1'b0;
            end else if (dec <= WARN_V) begin
              state_d = S_WARN;
              light_d = 1'b0;
            end
          end
        end
        S_WARN: begin
          if (bus.btn_toggle) begin
            state_d  = S_ON;
            light_d  = 1'b1;
            remain_d = AUTO_V;
          end else if (bus.sec_tick) begin
            remain_d = dec;
            state_d  = (dec == '0) ? S_OFF : S_WARN;
            light_d  = (dec == '0) ? 1'b0 : ~light_q;
          end
        end
        S_FORCED: begin
          state_d  = S_ON;
          light_d  = 1'b1;
          remain_d = AUTO_V;
        end
        default: begin
          state_d  = S_OFF;
          light_d  = 1'b0;
          remain_d = '0;
        end
      endcase
    end
  end
  assign bus.light       = light_q;
  assign bus.light_state = state_q;
  assign bus.remain_s    = remain_q;
endmodule
